// File: rtl/cpm_fifo_pack.sv
// rtl/cpm_fifo_pack.sv - narrow-in / wide-out packing FIFO; CPM_FIFO_PACK_ERR_EN adds ovf_cnt/udf_cnt error counters
module cpm_fifo_pack #(
  parameter int IN_WIDTH   = 16,
  parameter int RATIO      = 4,
  parameter int OUT_WIDTH  = IN_WIDTH * RATIO,
  parameter int ADDR_WIDTH = 4,
  parameter int RAM_DEPTH  = 1 << ADDR_WIDTH,
  parameter int REG_OUT    = 0,
  parameter int AF_THRESH  = RAM_DEPTH - 2,
  parameter int AE_THRESH  = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       Reset,
  input  logic                       push,
  input  logic [IN_WIDTH-1:0]        data_in,
  input  logic                       flush,
  input  logic                       pop,
  output logic [OUT_WIDTH-1:0]       data_out,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [ADDR_WIDTH:0]        fifo_count,
  output logic [ADDR_WIDTH:0]        fifo_count_empty,
  output logic [$clog2(RATIO)-1:0]   pack_cnt
`ifdef CPM_FIFO_PACK_ERR_EN
  ,
  output logic [7:0]                 ovf_cnt,
  output logic [7:0]                 udf_cnt
`endif
);

  localparam int PCW      = $clog2(RATIO);
  localparam int CW       = ADDR_WIDTH + 1;
  localparam int RATIO_M1 = RATIO - 1;

  localparam logic [PCW-1:0] LAST_LANE = RATIO_M1[PCW-1:0];
  localparam logic [CW-1:0]  DEPTH_C   = RAM_DEPTH[CW-1:0];
  localparam logic [CW-1:0]  AF_C      = AF_THRESH[CW-1:0];
  localparam logic [CW-1:0]  AE_C      = AE_THRESH[CW-1:0];

  // Pack register: lane 0 holds the first pushed word of the pending output word.
  logic [RATIO-1:0][IN_WIDTH-1:0] pack_reg;
  logic [RATIO-1:0][IN_WIDTH-1:0] wr_word;

  logic [OUT_WIDTH-1:0]  mem [RAM_DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CW-1:0]         count_q;
  logic [CW-1:0]         count_empty_q;

  logic push_acc;
  logic pop_acc;
  logic word_done;
  logic pend_nz;
  logic flush_acc;
  logic commit;

  // Flags come straight from the registered counts.
  assign empty        = (count_q == '0);
  assign full         = (count_q == DEPTH_C) && (pack_cnt == LAST_LANE);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);

  assign fifo_count       = count_q;
  assign fifo_count_empty = count_empty_q;

  // Acceptance decisions; a flush only matters if a partial word remains after this cycle's push.
  always_comb begin
    push_acc  = push && !full;
    pop_acc   = pop && !empty;
    word_done = push_acc && (pack_cnt == LAST_LANE);
    pend_nz   = push_acc || (pack_cnt != '0);
    flush_acc = flush && !word_done && pend_nz && (count_q != DEPTH_C);
    commit    = word_done || flush_acc;
  end

  // Word written to storage: the register plus this cycle's pushed lane; unfilled lanes are already zero.
  always_comb begin
    wr_word = pack_reg;
    if (push_acc) begin
      wr_word[pack_cnt] = data_in;
    end
  end

  // Pack register and lane counter; both return to zero whenever a word is committed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pack_reg <= '0;
      pack_cnt <= '0;
    end else if (Reset) begin
      pack_reg <= '0;
      pack_cnt <= '0;
    end else if (commit) begin
      pack_reg <= '0;
      pack_cnt <= '0;
    end else if (push_acc) begin
      pack_reg[pack_cnt] <= data_in;
      pack_cnt           <= pack_cnt + PCW'(1);
    end
  end

  // Storage array; only the hard reset clears it, the soft clear leaves contents intact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RAM_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (!Reset && commit) begin
      mem[wr_ptr] <= wr_word;
    end
  end

  // Pointers and occupancy counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count_q       <= '0;
      count_empty_q <= DEPTH_C;
    end else if (Reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count_q       <= '0;
      count_empty_q <= DEPTH_C;
    end else begin
      if (commit) begin
        wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      end
      if (pop_acc) begin
        rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      end
      case ({commit, pop_acc})
        2'b10: begin
          count_q       <= count_q + CW'(1);
          count_empty_q <= count_empty_q - CW'(1);
        end
        2'b01: begin
          count_q       <= count_q - CW'(1);
          count_empty_q <= count_empty_q + CW'(1);
        end
        default: begin
          count_q       <= count_q;
          count_empty_q <= count_empty_q;
        end
      endcase
    end
  end

  generate
    if (REG_OUT != 0) begin : g_reg_out
      logic [OUT_WIDTH-1:0] data_q;

      // Registered output: captures the head word on each accepted pop, otherwise holds.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_q <= '0;
        end else if (Reset) begin
          data_q <= '0;
        end else if (pop_acc) begin
          data_q <= mem[rd_ptr];
        end
      end

      assign data_out = data_q;
    end else begin : g_comb_out
      assign data_out = mem[rd_ptr];
    end
  endgenerate

`ifdef CPM_FIFO_PACK_ERR_EN
  // Saturating counters of rejected pushes and pops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt <= '0;
      udf_cnt <= '0;
    end else if (Reset) begin
      ovf_cnt <= '0;
      udf_cnt <= '0;
    end else begin
      if (push && full && (ovf_cnt != 8'hFF)) begin
        ovf_cnt <= ovf_cnt + 8'd1;
      end
      if (pop && empty && (udf_cnt != 8'hFF)) begin
        udf_cnt <= udf_cnt + 8'd1;
      end
    end
  end
`endif

endmodule
